// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first) with RX FIFO, demo-system device bus and level IRQ.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int FifoDepth      = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);

  localparam int ClocksPerBit = ClockFrequency / BaudRate;
  localparam int HalfBit      = ClocksPerBit / 2;
  localparam int CntW         = $clog2(ClocksPerBit + 1);
  localparam int PtrW         = $clog2(FifoDepth);
  localparam int CountW       = $clog2(FifoDepth + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(ClocksPerBit - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] StParity = 3'd3;
`endif

  logic            rxSync1_q, rxSync2_q, rxPrev_q;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      fifoMem_q [FifoDepth];
  logic [PtrW-1:0] wrPtr_q, rdPtr_q;
  logic [CountW-1:0] count_q;
  logic            overrun_q, frameErr_q, parityErr;
  logic [1:0]      ctrl_q;
  logic            rvalid_q, irq_q, irq_d;
  logic [31:0]     rdata_q, rdata_d, readVal;
  logic            pushReq, frameSet, push, pop, notEmpty, full, isRead, isWrite;
  logic [1:0]      addrSel;
  logic [2:0]      clrMask;
  logic            unusedBits;

`ifdef UART_RX_PARITY_EN
  logic parityBad_q, parityBad_d, parityErr_q, paritySet;
  assign parityErr = parityErr_q;
`else
  assign parityErr = 1'b0;
`endif

  assign unusedBits = ^{device_addr_i[31:4], device_addr_i[1:0], device_be_i[3:1],
                        device_wdata_i[31:4]};

  assign addrSel  = device_addr_i[3:2];
  assign isRead   = device_req_i & ~device_we_i;
  assign isWrite  = device_req_i & device_we_i;
  assign notEmpty = (count_q != '0);
  assign full     = (count_q == CountW'(FifoDepth));
  assign pop      = isRead && (addrSel == 2'd0) && notEmpty;
  assign push     = pushReq & ~full;
  assign clrMask  = (isWrite && (addrSel == 2'd1) && device_be_i[0]) ? device_wdata_i[4:2] : 3'b000;

  // Receive FSM: the start bit is re-checked at its midpoint, later bits one bit-time apart.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    pushReq  = 1'b0;
    frameSet = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBad_d = parityBad_q;
    paritySet   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (rxPrev_q && !rxSync2_q) begin
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          if (rxSync2_q) begin
            state_d = StIdle;
          end else begin
            cnt_d   = '0;
            idx_d   = 3'd0;
            state_d = StData;
`ifdef UART_RX_PARITY_EN
            parityBad_d = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          shreg_d = {rxSync2_q, shreg_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BitLast) begin
          parityBad_d = ^{shreg_q, rxSync2_q};
          paritySet   = parityBad_d;
          cnt_d       = '0;
          state_d     = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (cnt_q == BitLast) begin
          if (rxSync2_q) begin
            pushReq = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (parityBad_q) pushReq = 1'b0;
`endif
          end else begin
            frameSet = 1'b1;
          end
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    readVal = 32'h0;
    case (addrSel)
      2'd0: readVal = notEmpty ? {24'h0, fifoMem_q[rdPtr_q]} : 32'h8000_0000;
      2'd1: readVal = {27'h0, parityErr, frameErr_q, overrun_q, full, notEmpty};
      2'd2: readVal = {30'h0, ctrl_q};
      default: readVal = 32'h0;
    endcase
    rdata_d = isRead ? readVal : 32'h0;
    irq_d   = (ctrl_q[0] & notEmpty) | (ctrl_q[1] & (overrun_q | frameErr_q | parityErr));
  end

  // Hardware-set sticky flags win over a same-cycle write-1-to-clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rxSync1_q  <= 1'b1;
      rxSync2_q  <= 1'b1;
      rxPrev_q   <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      shreg_q    <= 8'h0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
      ctrl_q     <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      irq_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      rxSync1_q  <= uart_rx_i;
      rxSync2_q  <= rxSync1_q;
      rxPrev_q   <= rxSync2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      if (push) wrPtr_q <= wrPtr_q + PtrW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PtrW'(1);
      count_q    <= count_q + CountW'(push) - CountW'(pop);
      overrun_q  <= (overrun_q & ~clrMask[0]) | (pushReq & full);
      frameErr_q <= (frameErr_q & ~clrMask[1]) | frameSet;
      if (isWrite && (addrSel == 2'd2) && device_be_i[0]) ctrl_q <= device_wdata_i[1:0];
      rvalid_q   <= device_req_i;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= parityBad_d;
      parityErr_q <= (parityErr_q & ~clrMask[2]) | paritySet;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifoMem_q[wrPtr_q] <= shreg_q;
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign irq_o           = irq_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

   localparam logic [31:0] AddrData   = 32'h0;
   localparam logic [31:0] AddrStatus = 32'h4;
   localparam logic [31:0] AddrCtrl   = 32'h8;
   localparam logic [31:0] AddrSpare  = 32'hC;

   logic        clock = 1'b0;
   logic        resetN;
   logic        devReq;
   logic [31:0] devAddr;
   logic        devWe;
   logic [3:0]  devBe;
   logic [31:0] devWdata;
   logic        devRvalid;
   logic [31:0] devRdata;
   logic        serialIn;
   logic        irq;

   int assertCount = 0;
   int failCount = 0;

   uart_rx #(
      .ClockFrequency(1_000_000),
      .BaudRate(100_000),
      .FifoDepth(8)
   ) dut (
      .clk_i(clock),
      .rst_ni(resetN),
      .device_req_i(devReq),
      .device_addr_i(devAddr),
      .device_we_i(devWe),
      .device_be_i(devBe),
      .device_wdata_i(devWdata),
      .device_rvalid_o(devRvalid),
      .device_rdata_o(devRdata),
      .uart_rx_i(serialIn),
      .irq_o(irq)
   );

   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // One bus request; the response must arrive on the very next clock with the given data.
   task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic we,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] expRdata);
      @(negedge clock);
      devReq   = 1'b1;
      devAddr  = addr;
      devWe    = we;
      devWdata = wdata;
      devBe    = be;
      @(posedge clock);
      #1;
      checkOutput({tag, " rvalid"}, {31'h0, devRvalid}, 32'h1);
      checkOutput(tag, devRdata, expRdata);
      devReq   = 1'b0;
      devWe    = 1'b0;
      devWdata = 32'h0;
      devBe    = 4'h0;
   endtask

   // Drives one frame; the stop bit can be shortened so the caller can probe mid-stop.
   task automatic sendByte(input logic [7:0] data, input logic stopBit, input int stopClocks);
      logic [9:0] frame;
      frame = {stopBit, data, 1'b0};
      @(negedge clock);
      for (int i = 0; i < 10; i++) begin
         serialIn = frame[i];
         repeat ((i == 9) ? stopClocks : 10) @(negedge clock);
      end
      serialIn = 1'b1;
   endtask

   initial begin
      resetN   = 1'b0;
      serialIn = 1'b1;
      devReq   = 1'b0;
      devAddr  = 32'h0;
      devWe    = 1'b0;
      devBe    = 4'h0;
      devWdata = 32'h0;
      repeat (3) @(negedge clock);
      checkOutput("reset rvalid", {31'h0, devRvalid}, 32'h0);
      checkOutput("reset rdata", devRdata, 32'h0);
      checkOutput("reset irq", {31'h0, irq}, 32'h0);
      resetN = 1'b1;
      repeat (2) @(negedge clock);

      $display("[TB] post-reset register reads");
      applyStimulus("status after reset", AddrStatus, 1'b0, 32'h0, 4'hF, 32'h0);
      applyStimulus("rxdata empty", AddrData, 1'b0, 32'h0, 4'hF, 32'h8000_0000);
      applyStimulus("ctrl after reset", AddrCtrl, 1'b0, 32'h0, 4'hF, 32'h0);
      applyStimulus("spare read", AddrSpare, 1'b0, 32'h0, 4'hF, 32'h0);
      checkOutput("irq idle", {31'h0, irq}, 32'h0);

      $display("[TB] single frame 0xA5");
      sendByte(8'hA5, 1'b1, 10);
      applyStimulus("status one byte", AddrStatus, 1'b0, 32'h0, 4'hF, 32'h1);
      applyStimulus("rxdata A5", AddrData, 1'b0, 32'h0, 4'hF, 32'hA5);
      applyStimulus("status after pop", AddrStatus, 1'b0, 32'h0, 4'hF, 32'h0);

      $display("[TB] receive interrupt");
      applyStimulus("ctrl write", AddrCtrl, 1'b1, 32'h1, 4'h1, 32'h0);
      applyStimulus("ctrl readback", AddrCtrl, 1'b0, 32'h0, 4'hF, 32'h1);
      sendByte(8'h3C, 1'b1, 7);
      checkOutput("irq before push", {31'h0, irq}, 32'h0);
      repeat (2) @(negedge clock);
      checkOutput("irq after push", {31'h0, irq}, 32'h1);
      repeat (3) @(negedge clock);
      applyStimulus("rxdata 3C", AddrData, 1'b0, 32'h0, 4'hF, 32'h3C);
      checkOutput("irq at pop", {31'h0, irq}, 32'h1);
      @(posedge clock);
      #1;
      checkOutput("irq after pop", {31'h0, irq}, 32'h0);
      applyStimulus("ctrl clear", AddrCtrl, 1'b1, 32'h0, 4'h1, 32'h0);
      applyStimulus("ctrl write no be0", AddrCtrl, 1'b1, 32'h3, 4'h2, 32'h0);
      applyStimulus("ctrl unchanged", AddrCtrl, 1'b0, 32'h0, 4'hF, 32'h0);

      $display("[TB] FIFO fill and overrun");
      for (int b = 0; b < 9; b++) sendByte(8'(b), 1'b1, 10);
      applyStimulus("status full overrun", AddrStatus, 1'b0, 32'h0, 4'hF, 32'h7);
      for (int b = 0; b < 8; b++) applyStimulus($sformatf("fifo byte %0d", b), AddrData, 1'b0, 32'h0, 4'hF, 32'(b));
      applyStimulus("fifo drained", AddrData, 1'b0, 32'h0, 4'hF, 32'h8000_0000);
      applyStimulus("status overrun only", AddrStatus, 1'b0, 32'h0, 4'hF, 32'h4);
      applyStimulus("clear overrun", AddrStatus, 1'b1, 32'h4, 4'h1, 32'h0);
      applyStimulus("status cleared", AddrStatus, 1'b0, 32'h0, 4'hF, 32'h0);

      $display("[TB] frame error");
      sendByte(8'h55, 1'b0, 10);
      repeat (2) @(negedge clock);
      applyStimulus("status frame err", AddrStatus, 1'b0, 32'h0, 4'hF, 32'h8);
      applyStimulus("rxdata after frame err", AddrData, 1'b0, 32'h0, 4'hF, 32'h8000_0000);
      applyStimulus("clear frame err", AddrStatus, 1'b1, 32'h8, 4'h1, 32'h0);
      applyStimulus("status frame cleared", AddrStatus, 1'b0, 32'h0, 4'hF, 32'h0);

      $display("[TB] false start glitch");
      @(negedge clock);
      serialIn = 1'b0;
      repeat (3) @(negedge clock);
      serialIn = 1'b1;
      repeat (20) @(negedge clock);
      applyStimulus("status after glitch", AddrStatus, 1'b0, 32'h0, 4'hF, 32'h0);
      sendByte(8'h5A, 1'b1, 10);
      applyStimulus("rxdata after glitch", AddrData, 1'b0, 32'h0, 4'hF, 32'h5A);

      $display("[TB] reset during a frame");
      sendByte(8'h77, 1'b1, 10);
      applyStimulus("ctrl irq on", AddrCtrl, 1'b1, 32'h1, 4'h1, 32'h0);
      repeat (2) @(negedge clock);
      checkOutput("irq before reset", {31'h0, irq}, 32'h1);
      serialIn = 1'b0;
      repeat (10) @(negedge clock);
      serialIn = 1'b1;
      repeat (30) @(negedge clock);
      resetN = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("midframe reset rvalid", {31'h0, devRvalid}, 32'h0);
      checkOutput("midframe reset rdata", devRdata, 32'h0);
      checkOutput("midframe reset irq", {31'h0, irq}, 32'h0);
      resetN = 1'b1;
      repeat (100) @(negedge clock);
      applyStimulus("status after reset 2", AddrStatus, 1'b0, 32'h0, 4'hF, 32'h0);
      @(posedge clock);
      #1;
      checkOutput("rvalid deasserts", {31'h0, devRvalid}, 32'h0);
      applyStimulus("ctrl after reset 2", AddrCtrl, 1'b0, 32'h0, 4'hF, 32'h0);
      applyStimulus("rxdata after reset 2", AddrData, 1'b0, 32'h0, 4'hF, 32'h8000_0000);
      sendByte(8'h12, 1'b1, 10);
      applyStimulus("rxdata 12", AddrData, 1'b0, 32'h0, 4'hF, 32'h12);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
